// File: rtl/noise_gate_pkg.sv
// -----------------------------------------------------------------------------
// noise_gate_pkg
//   Shared types and constants for the noise gate block.
//   - gate_state_e : gate state machine encoding
//   - GAIN_W       : width of the gain word (unsigned, UNITY_GAIN = 1.0)
//   - COUNT_W      : width of the hold counter
//   - UNITY_GAIN   : gain value that passes the sample through unchanged
//   - gain_add_sat / gain_sub_sat : step the gain without leaving 0..UNITY_GAIN
// -----------------------------------------------------------------------------
package noise_gate_pkg;

    localparam int unsigned GAIN_W  = 16;
    localparam int unsigned COUNT_W = 16;

    localparam logic [GAIN_W-1:0] UNITY_GAIN = 16'h8000;
    localparam logic [GAIN_W-1:0] ZERO_GAIN  = 16'h0000;

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_ATTACK,
        ST_OPEN,
        ST_HOLD,
        ST_RELEASE
    } gate_state_e;

    // The sum is formed one bit wider than the gain so that a large step
    // near unity cannot wrap before it is clamped.
    function automatic logic [GAIN_W-1:0] gain_add_sat(
        input logic [GAIN_W-1:0] gain,
        input logic [GAIN_W-1:0] step
    );
        logic [GAIN_W:0] sum;
        sum = {1'b0, gain} + {1'b0, step};
        if (sum > {1'b0, UNITY_GAIN}) begin
            return UNITY_GAIN;
        end
        return sum[GAIN_W-1:0];
    endfunction

    // The wide difference goes negative (top bit set) exactly when the step
    // is larger than the remaining gain; that case floors at zero.
    function automatic logic [GAIN_W-1:0] gain_sub_sat(
        input logic [GAIN_W-1:0] gain,
        input logic [GAIN_W-1:0] step
    );
        logic [GAIN_W:0] diff;
        diff = {1'b0, gain} - {1'b0, step};
        if (diff[GAIN_W]) begin
            return ZERO_GAIN;
        end
        return diff[GAIN_W-1:0];
    endfunction

endpackage

// File: rtl/gate_gain_mul.sv
// -----------------------------------------------------------------------------
// gate_gain_mul
//   Combinational gain stage: y = (x * gain) >>> 15, where x is signed Q1.15
//   and gain is unsigned with 16'h8000 = unity. The gain is zero-extended to
//   17 bits so it multiplies as a positive number, the 33-bit product is
//   shifted arithmetically and truncated back to 16 bits.
//
//   Ports
//     x    : in  signed Q1.15 sample
//     gain : in  unsigned gain, 16'h8000 = unity
//     y    : out signed Q1.15 scaled sample
// -----------------------------------------------------------------------------
module gate_gain_mul
    import noise_gate_pkg::*;
(
    input  logic signed [15:0]       x,
    input  logic        [GAIN_W-1:0] gain,
    output logic signed [15:0]       y
);

    logic signed [32:0] product;
    logic signed [32:0] shifted;

    always_comb begin
        product = $signed(x) * $signed({1'b0, gain});
        shifted = product >>> 15;
        // -1.0 * unity lands on -1.0 exactly, so truncation never overflows
        // for gains within 0..UNITY_GAIN.
        y       = 16'(shifted);
    end

endmodule

// File: rtl/noise_gate.sv
// -----------------------------------------------------------------------------
// noise_gate
//   Level-driven audio noise gate. An upstream RMS meter supplies a level for
//   every sample; the gate opens (ramping the gain up) when the level reaches
//   thr_open, holds for HOLD_SAMPLES once it falls below the close threshold,
//   then ramps the gain down to silence. The gain ramp gives click-free
//   transitions; the two thresholds give hysteresis.
//
//   All state advances only on samples (x_valid=1); idle cycles change
//   nothing but y_valid. The output sample uses the gain in force before the
//   same-edge update, with one cycle of latency.
//
//   Ports
//     clk       : in  clock, rising edge
//     rst       : in  synchronous active-high reset
//     x_in      : in  signed Q1.15 audio sample
//     x_valid   : in  qualifies x_in and rms_in
//     rms_in    : in  unsigned level, same scale as the thresholds
//     thr_open  : in  open threshold (level >= thr_open opens)
//     thr_close : in  close threshold (level < min(thr_close, thr_open) closes)
//     y_out     : out signed Q1.15 gated sample, held between valid pulses
//     y_valid   : out one-cycle pulse the cycle after each x_valid
//     gate_open : out high in every state except CLOSED
//     gain_out  : out current gain, 16'h8000 = unity
// -----------------------------------------------------------------------------
module noise_gate
    import noise_gate_pkg::*;
#(
    parameter int unsigned       HOLD_SAMPLES = 4800,
    parameter logic [GAIN_W-1:0] ATTACK_STEP  = 16'd64,
    parameter logic [GAIN_W-1:0] RELEASE_STEP = 16'd8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [15:0]       x_in,
    input  logic                     x_valid,
    input  logic        [15:0]       rms_in,
    input  logic        [15:0]       thr_open,
    input  logic        [15:0]       thr_close,
    output logic signed [15:0]       y_out,
    output logic                     y_valid,
    output logic                     gate_open,
    output logic        [GAIN_W-1:0] gain_out
);

    // Counter runs HOLD_SAMPLES-1 down to 0, so the gate spends exactly
    // HOLD_SAMPLES samples in HOLD before releasing.
    localparam logic [COUNT_W-1:0] HOLD_LOAD = COUNT_W'(HOLD_SAMPLES - 1);

    gate_state_e        state;
    gate_state_e        state_next;
    logic [GAIN_W-1:0]  gain;
    logic [GAIN_W-1:0]  gain_next;
    logic [COUNT_W-1:0] hold_cnt;
    logic [COUNT_W-1:0] hold_next;

    logic [15:0]        thr_close_eff;
    logic               open_cond;
    logic               close_cond;
    logic [GAIN_W-1:0]  gain_up;
    logic [GAIN_W-1:0]  gain_dn;
    logic signed [15:0] y_prod;

    // A close threshold above the open threshold would let the level sit in
    // a band where both conditions are true; clamping it keeps the gate from
    // chattering between OPEN and HOLD.
    assign thr_close_eff = (thr_close < thr_open) ? thr_close : thr_open;
    assign open_cond     = (rms_in >= thr_open);
    assign close_cond    = (rms_in < thr_close_eff);

    assign gain_up = gain_add_sat(gain, ATTACK_STEP);
    assign gain_dn = gain_sub_sat(gain, RELEASE_STEP);

    // Product uses the registered gain, i.e. the value before this sample's
    // update.
    gate_gain_mul u_mul (
        .x    (x_in),
        .gain (gain),
        .y    (y_prod)
    );

    // -------------------------------------------------------------------------
    // Next-state / next-gain logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path through the case leaves a value unassigned and no latch forms.
        state_next = state;
        gain_next  = gain;
        hold_next  = hold_cnt;

        unique case (state)
            ST_CLOSED: begin
                gain_next = ZERO_GAIN;
                if (open_cond) begin
                    // The opening sample already takes the first attack step.
                    gain_next  = gain_up;
                    state_next = (gain_up == UNITY_GAIN) ? ST_OPEN : ST_ATTACK;
                end
            end

            ST_ATTACK: begin
                // Level is deliberately ignored: a started attack always
                // completes, avoiding a gain ramp that reverses mid-way.
                gain_next = gain_up;
                if (gain_up == UNITY_GAIN) begin
                    state_next = ST_OPEN;
                end
            end

            ST_OPEN: begin
                gain_next = UNITY_GAIN;
                if (close_cond) begin
                    state_next = ST_HOLD;
                    hold_next  = HOLD_LOAD;
                end
            end

            ST_HOLD: begin
                if (open_cond) begin
                    state_next = ST_OPEN;
                end else if (hold_cnt == '0) begin
                    state_next = ST_RELEASE;
                end else begin
                    hold_next = hold_cnt - COUNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (open_cond) begin
                    // Re-attack from the current gain; no decrement this sample.
                    gain_next  = gain_up;
                    state_next = (gain_up == UNITY_GAIN) ? ST_OPEN : ST_ATTACK;
                end else begin
                    gain_next = gain_dn;
                    if (gain_dn == ZERO_GAIN) begin
                        state_next = ST_CLOSED;
                    end
                end
            end

            default: begin
                state_next = ST_CLOSED;
                gain_next  = ZERO_GAIN;
                hold_next  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, gain, counter and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, whatever the statement order.
        if (rst) begin
            state     <= ST_CLOSED;
            gain      <= ZERO_GAIN;
            hold_cnt  <= '0;
            y_out     <= '0;
            y_valid   <= 1'b0;
            gate_open <= 1'b0;
        end else begin
            y_valid <= x_valid;
            if (x_valid) begin
                state     <= state_next;
                gain      <= gain_next;
                hold_cnt  <= hold_next;
                y_out     <= y_prod;
                gate_open <= (state_next != ST_CLOSED);
            end
        end
    end

    assign gain_out = gain;

endmodule

// File: tb/tb_noise_gate.sv
// -----------------------------------------------------------------------------
// tb_noise_gate
//   Self-checking bench for noise_gate. Each sample pushes its expected output
//   onto a scoreboard queue; a monitor pops and compares whenever y_valid is
//   seen. Gain and gate_open expectations are given per sample by the tests.
// -----------------------------------------------------------------------------
module tb_noise_gate;

    localparam int unsigned HOLD         = 4;
    localparam logic [15:0] ATTACK_STEP  = 16'h2000;
    localparam logic [15:0] RELEASE_STEP = 16'h1000;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] x_in;
    logic               x_valid;
    logic        [15:0] rms_in;
    logic        [15:0] thr_open;
    logic        [15:0] thr_close;
    logic signed [15:0] y_out;
    logic               y_valid;
    logic               gate_open;
    logic        [15:0] gain_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] y_q[$];
    logic [15:0] exp_gain;     // gain the DUT should hold right now
    logic [15:0] exp_y_last;   // value y_out should be holding
    logic [15:0] mon_exp;

    always #5 clk = ~clk;

    noise_gate #(
        .HOLD_SAMPLES (HOLD),
        .ATTACK_STEP  (ATTACK_STEP),
        .RELEASE_STEP (RELEASE_STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .rms_in    (rms_in),
        .thr_open  (thr_open),
        .thr_close (thr_close),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .gate_open (gate_open),
        .gain_out  (gain_out)
    );

    // Reference gain stage: sign-extend, multiply at 33 bits, take bits 30:15.
    function automatic logic [15:0] ref_y(input logic [15:0] x, input logic [15:0] g);
        logic signed [32:0] p;
        p = $signed({{17{x[15]}}, x}) * $signed({17'b0, g});
        return p[30:15];
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (y_valid === 1'b1) begin
            checks++;
            if (y_q.size() == 0) begin
                errors++;
                $display("FAIL y_valid_unexpected: y_valid=1 with no pending sample at %0t", $time);
            end else begin
                mon_exp = y_q.pop_front();
                if (y_out !== mon_exp) begin
                    errors++;
                    $display("FAIL y_out: got %h want %h at %0t", y_out, mon_exp, $time);
                end
            end
        end
    end

    // One sample; called at a falling edge, returns at the next falling edge.
    task automatic do_sample(input logic [15:0] x, input logic [15:0] rms,
                             input logic [15:0] g_after, input logic open_after,
                             input string tag);
        x_in       = x;
        rms_in     = rms;
        x_valid    = 1'b1;
        exp_y_last = ref_y(x, exp_gain);
        y_q.push_back(exp_y_last);
        exp_gain   = g_after;
        @(negedge clk);
        x_valid = 1'b0;
        checks++;
        if (y_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s y_valid: got %b want 1", tag, y_valid);
        end
        checks++;
        if (gain_out !== g_after) begin
            errors++;
            $display("FAIL %s gain_out: got %h want %h", tag, gain_out, g_after);
        end
        checks++;
        if (gate_open !== open_after) begin
            errors++;
            $display("FAIL %s gate_open: got %b want %b", tag, gate_open, open_after);
        end
    endtask

    // Idle cycles: nothing but y_valid may move, and it must stay low.
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (y_valid !== 1'b0 || gain_out !== exp_gain || y_out !== exp_y_last) begin
                errors++;
                $display("FAIL %s idle: y_valid=%b gain=%h y=%h want 0/%h/%h",
                         tag, y_valid, gain_out, y_out, exp_gain, exp_y_last);
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        x_valid   = 1'b0;
        x_in      = 16'h0;
        rms_in    = 16'h0;
        thr_open  = 16'h1000;
        thr_close = 16'h0800;
        repeat (3) @(negedge clk);
        checks++;
        if (y_out !== 16'h0 || y_valid !== 1'b0 || gate_open !== 1'b0 || gain_out !== 16'h0) begin
            errors++;
            $display("FAIL reset: y=%h yv=%b open=%b gain=%h want all 0",
                     y_out, y_valid, gate_open, gain_out);
        end
        rst        = 1'b0;
        exp_gain   = 16'h0;
        exp_y_last = 16'h0;
    endtask

    task automatic test_closed();
        for (int i = 0; i < 10; i++)
            do_sample(16'h4000, 16'h0100, 16'h0000, 1'b0, "closed");
    endtask

    task automatic attack_from_closed(input string tag);
        for (int i = 1; i <= 4; i++)
            do_sample(16'h4000, 16'h2000, 16'(i * 16'h2000), 1'b1, tag);
    endtask

    task automatic test_attack();
        attack_from_closed("attack");
        do_sample(16'h4000, 16'h2000, 16'h8000, 1'b1, "attack_open");
    endtask

    task automatic test_hold_release();
        for (int i = 0; i < 1 + HOLD; i++)
            do_sample(16'h4000, 16'h0400, 16'h8000, 1'b1, "hold");
        for (int i = 1; i <= 8; i++)
            do_sample(16'h4000, 16'h0400, 16'(16'h8000 - i * 16'h1000), (i < 8), "release");
        do_sample(16'h4000, 16'h0400, 16'h0000, 1'b0, "closed_after_release");
    endtask

    task automatic test_hold_reopen();
        attack_from_closed("reattack");
        for (int i = 0; i < 3; i++)
            do_sample(16'h4000, 16'h0400, 16'h8000, 1'b1, "hold_partial");
        do_sample(16'h4000, 16'h1000, 16'h8000, 1'b1, "hold_reopen");
        // Reopened: a fresh close must run the full hold again.
        for (int i = 0; i < 1 + HOLD; i++)
            do_sample(16'h4000, 16'h0400, 16'h8000, 1'b1, "hold_full");
        for (int i = 1; i <= 3; i++)
            do_sample(16'h4000, 16'h0400, 16'(16'h8000 - i * 16'h1000), 1'b1, "release_part");
        do_sample(16'h4000, 16'h2000, 16'h7000, 1'b1, "release_reattack");
        do_sample(16'h4000, 16'h2000, 16'h8000, 1'b1, "reattack_sat");
        do_sample(16'h4000, 16'h2000, 16'h8000, 1'b1, "reattack_open");
    endtask

    task automatic test_full_scale_gaps();
        do_sample(16'h8000, 16'h2000, 16'h8000, 1'b1, "full_neg");
        do_sample(16'h7fff, 16'h2000, 16'h8000, 1'b1, "full_pos");
        idle(3, "gap_open");
        for (int i = 0; i < 1 + HOLD; i++) begin
            do_sample(16'hc000, 16'h0400, 16'h8000, 1'b1, "gap_hold");
            idle(3, "gap_hold");
        end
        for (int i = 1; i <= 5; i++) begin
            do_sample(16'hc000, 16'h0400, 16'(16'h8000 - i * 16'h1000), 1'b1, "gap_release");
            idle(3, "gap_release");
        end
    endtask

    task automatic test_reset_mid();
        // Gain is 0x3000 in RELEASE here; reset must win over a valid sample.
        rst     = 1'b1;
        x_valid = 1'b1;
        x_in    = 16'h4000;
        rms_in  = 16'h2000;
        @(negedge clk);
        rst     = 1'b0;
        x_valid = 1'b0;
        checks++;
        if (y_out !== 16'h0 || y_valid !== 1'b0 || gate_open !== 1'b0 || gain_out !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid: y=%h yv=%b open=%b gain=%h want all 0",
                     y_out, y_valid, gate_open, gain_out);
        end
        exp_gain   = 16'h0;
        exp_y_last = 16'h0;
        attack_from_closed("post_reset");
    endtask

    task automatic test_thresholds();
        thr_close = 16'h2000;
        do_sample(16'h4000, 16'h1800, 16'h8000, 1'b1, "thc_stay_open");
        for (int i = 0; i < 1 + HOLD; i++)
            do_sample(16'h4000, 16'h0fff, 16'h8000, 1'b1, "thc_hold");
        do_sample(16'h4000, 16'h0fff, 16'h7000, 1'b1, "thc_release");
    endtask

    initial begin
        test_reset();
        test_closed();
        test_attack();
        test_hold_release();
        test_hold_reopen();
        test_full_scale_gaps();
        test_reset_mid();
        test_thresholds();
        @(negedge clk);
        checks++;
        if (y_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d outputs never seen, want 0", y_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
